// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: decode-side control in, IF/ID register and PC out.
`timescale 1ns/1ps
interface instruction_fetch_unit_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instr_in;
   logic [31:0] pc;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        halted;
   logic [31:0] fetch_count;

   // Fetch unit side
   modport master (
      input  stall, redirect, redirect_pc, instr_in,
      output pc, if_id_pc, if_id_instr, if_id_valid, halted, fetch_count
   );

   // Pipeline / instruction memory side
   modport slave (
      output stall, redirect, redirect_pc, instr_in,
      input  pc, if_id_pc, if_id_instr, if_id_valid, halted, fetch_count
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// LEGv8 fetch stage: owns the PC, fills the IF/ID register, handles
// stalls, branch redirects with a one-bubble flush, and halts past the image.
`timescale 1ns/1ps
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_DEPTH = 7
) (
   input logic                       clk,
   input logic                       rst_n,
   instruction_fetch_unit_if.master  bus
);
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      OP_RUN   = 2'd0,
      OP_STALL = 2'd1,
      OP_HALT  = 2'd2,
      OP_REDIR = 2'd3
   } fetch_op_e;

   // Fetch count saturates instead of wrapping back to zero.
   function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
      sat_inc = (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   logic [DATA_W-1:0] r_pc;
   logic [DATA_W-1:0] r_fetch_count;
   // IF/ID boundary registers
   logic [DATA_W-1:0] r_ifid_pc_p1;
   logic [DATA_W-1:0] r_ifid_instr_p1;
   logic              r_ifid_vld_p1;

   logic [DATA_W-1:0] w_pc_nxt;
   logic [DATA_W-1:0] w_fetch_count_nxt;
   logic [DATA_W-1:0] w_ifid_pc_nxt;
   logic [DATA_W-1:0] w_ifid_instr_nxt;
   logic              w_ifid_vld_nxt;
   logic [DATA_W-1:0] w_target;
   logic              w_halted;
   fetch_op_e         w_op;

   // Low two target bits are dropped so every fetch address is word aligned.
   assign w_target = bus.redirect_pc & 32'hFFFF_FFFC;

   // Out of the loaded image when the word index reaches the depth.
   assign w_halted = ({2'b00, r_pc[31:2]} >= IMEM_DEPTH);

   // Priority select of the cycle's action and next-state values.
   always_comb begin
      w_op              = OP_RUN;
      w_pc_nxt          = r_pc;
      w_fetch_count_nxt = r_fetch_count;
      w_ifid_pc_nxt     = r_ifid_pc_p1;
      w_ifid_instr_nxt  = r_ifid_instr_p1;
      w_ifid_vld_nxt    = r_ifid_vld_p1;

      if (bus.redirect) begin
         w_op = OP_REDIR;
      end else if (bus.stall) begin
         w_op = OP_STALL;
      end else if (w_halted) begin
         w_op = OP_HALT;
      end

      case (w_op)
         OP_REDIR: begin
            w_pc_nxt       = w_target;
            w_ifid_vld_nxt = 1'b0;
         end
         OP_STALL: begin
         end
         OP_HALT: begin
            w_ifid_vld_nxt = 1'b0;
         end
         default: begin
            w_pc_nxt          = r_pc + 32'd4;
            w_ifid_pc_nxt     = r_pc;
            w_ifid_instr_nxt  = bus.instr_in;
            w_ifid_vld_nxt    = 1'b1;
            w_fetch_count_nxt = sat_inc(r_fetch_count);
         end
      endcase
   end

   // PC, fetch counter and IF/ID state update with async clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc            <= RESET_PC;
         r_fetch_count   <= '0;
         r_ifid_pc_p1    <= '0;
         r_ifid_instr_p1 <= '0;
         r_ifid_vld_p1   <= 1'b0;
      end else begin
         r_pc            <= w_pc_nxt;
         r_fetch_count   <= w_fetch_count_nxt;
         r_ifid_pc_p1    <= w_ifid_pc_nxt;
         r_ifid_instr_p1 <= w_ifid_instr_nxt;
         r_ifid_vld_p1   <= w_ifid_vld_nxt;
      end
   end

   assign bus.pc          = r_pc;
   assign bus.halted      = w_halted;
   assign bus.fetch_count = r_fetch_count;
   assign bus.if_id_pc    = r_ifid_pc_p1;
   assign bus.if_id_instr = r_ifid_instr_p1;
   assign bus.if_id_valid = r_ifid_vld_p1;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 7-word memory model.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   instruction_fetch_unit_if bus ();

   instruction_fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_DEPTH (7)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction memory: word i holds A000_0000 + i, garbage beyond the image.
   always_comb begin
      if (bus.pc[31:2] < 30'd7) bus.instr_in = 32'hA000_0000 + {2'b00, bus.pc[31:2]};
      else                      bus.instr_in = 32'hDEAD_BEEF;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] ipc, input logic [31:0] ins,
                           input logic vld, input logic [31:0] pc, input logic [31:0] fc);
      chk({tag, "_ifid_pc"}, bus.if_id_pc, ipc);
      chk({tag, "_ifid_instr"}, bus.if_id_instr, ins);
      chk({tag, "_ifid_valid"}, {31'd0, bus.if_id_valid}, {31'd0, vld});
      chk({tag, "_pc"}, bus.pc, pc);
      chk({tag, "_fcount"}, bus.fetch_count, fc);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'd0;

      // Reset state
      #12;
      chk_ifid("reset", 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      chk("reset_halted", {31'd0, bus.halted}, 32'd0);
      #4 rst_n = 1'b1;

      // Sequential fetch through the whole image
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk_ifid("seq", 32'(4*(k-1)), 32'hA000_0000 + 32'(k-1), 1'b1, 32'(4*k), 32'(k));
      end
      chk("seq_halted_at28", {31'd0, bus.halted}, 32'd1);
      tick();
      chk_ifid("halt", 32'd24, 32'hA000_0006, 1'b0, 32'd28, 32'd7);
      tick();
      chk_ifid("halt_hold", 32'd24, 32'hA000_0006, 1'b0, 32'd28, 32'd7);
      chk("halt_hold_halted", {31'd0, bus.halted}, 32'd1);

      // Recovery from halt by redirect to 0
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'd0;
      tick();
      chk_ifid("recov_redir", 32'd24, 32'hA000_0006, 1'b0, 32'd0, 32'd7);
      chk("recov_halted", {31'd0, bus.halted}, 32'd0);
      bus.redirect = 1'b0;
      tick();
      chk_ifid("recov_first", 32'd0, 32'hA000_0000, 1'b1, 32'd4, 32'd8);
      tick();
      chk_ifid("recov_second", 32'd4, 32'hA000_0001, 1'b1, 32'd8, 32'd9);

      // Stall for three cycles at pc = 8
      bus.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_ifid("stall", 32'd4, 32'hA000_0001, 1'b1, 32'd8, 32'd9);
      end
      bus.stall = 1'b0;
      tick();
      chk_ifid("stall_rel", 32'd8, 32'hA000_0002, 1'b1, 32'd12, 32'd10);
      tick();
      chk_ifid("stall_rel2", 32'd12, 32'hA000_0003, 1'b1, 32'd16, 32'd11);

      // Redirect with flush at pc = 16 to target 4
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'd4;
      tick();
      chk_ifid("redir", 32'd12, 32'hA000_0003, 1'b0, 32'd4, 32'd11);
      bus.redirect = 1'b0;
      tick();
      chk_ifid("redir_tgt", 32'd4, 32'hA000_0001, 1'b1, 32'd8, 32'd12);

      // Misaligned target, then redirect together with stall (back to back)
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0000_000B;
      tick();
      chk_ifid("misalign", 32'd4, 32'hA000_0001, 1'b0, 32'd8, 32'd12);
      bus.stall       = 1'b1;
      bus.redirect_pc = 32'h0000_0014;
      tick();
      chk_ifid("redir_stall", 32'd4, 32'hA000_0001, 1'b0, 32'd20, 32'd12);
      bus.redirect = 1'b0;
      bus.stall    = 1'b0;
      tick();
      chk_ifid("redir_stall_tgt", 32'd20, 32'hA000_0005, 1'b1, 32'd24, 32'd13);

      // Redirect out of range halts, stall while halted holds valid low
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFC;
      tick();
      bus.redirect = 1'b0;
      chk("far_halted", {31'd0, bus.halted}, 32'd1);
      tick();
      chk_ifid("far_hold", 32'd20, 32'hA000_0005, 1'b0, 32'hFFFF_FFFC, 32'd13);

      // Get to pc = 12, then async reset between edges
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'd8;
      tick();
      bus.redirect = 1'b0;
      tick();
      chk_ifid("pre_rst", 32'd8, 32'hA000_0002, 1'b1, 32'd12, 32'd14);
      #2 rst_n = 1'b0;
      #1;
      chk_ifid("async_rst", 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      chk("async_rst_halted", {31'd0, bus.halted}, 32'd0);
      #3 rst_n = 1'b1;
      tick();
      chk_ifid("post_rst", 32'd0, 32'hA000_0000, 1'b1, 32'd4, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the single-issue LEGv8 pipeline. Owns the program counter and drives it to the combinational instruction memory. Captures the returned instruction word into the IF/ID pipeline register for the decode stage. Handles decode-stage stalls, branch redirects with wrong-path flush, and an end-of-program halt when the PC runs past the loaded instruction image.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `IMEM_DEPTH`, default 7: number of valid 32-bit words in instruction memory.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall` input 1: decode/hazard stall request; hold PC and IF/ID.
- `redirect` input 1: branch/jump taken, resolved downstream.
- `redirect_pc` input 32: branch target byte address.
- `instr_in` input 32: instruction word returned combinationally by instruction memory for `pc`.
- `pc` output 32: current fetch address, driven to instruction memory.
- `if_id_pc` output 32: PC of the instruction held in IF/ID.
- `if_id_instr` output 32: instruction held in IF/ID.
- `if_id_valid` output 1: IF/ID holds a real instruction (0 = bubble).
- `halted` output 1: PC is outside the instruction image; fetch suspended.
- `fetch_count` output 32: number of instructions delivered to IF/ID (saturates at 32'hFFFF_FFFF).

## Operation
- In range: `pc[31:2] < IMEM_DEPTH`.
- `halted` is a combinational decode of the registered `pc`: asserted when `pc` is out of range.
- The next state is selected by priority, highest first:
  - **Redirect.** `pc` <= {`redirect_pc[31:2]`, 2'b00}; unaligned low bits are silently dropped. IF/ID: `if_id_valid` <= 0; `if_id_pc` and `if_id_instr` hold their values. `fetch_count` is unchanged. Redirect overrides `stall` and `halted`: a redirect to an in-range target restarts fetch.
  - **Stall.** `pc` and all IF/ID outputs and `fetch_count` hold.
  - **Halted.** `pc` holds. `if_id_valid` <= 0. `if_id_pc` and `if_id_instr` hold.
  - **Normal.** `if_id_pc` <= `pc`, `if_id_instr` <= `instr_in`, `if_id_valid` <= 1, `pc` <= `pc` + 4 (32-bit wrap, no carry-out), `fetch_count` <= `fetch_count` + 1 (saturating).
- Effective states: RUN (in range, no stall), STALL, HALT (out of range). Transitions are driven only by the priority rules above.
- `instr_in` is sampled only in the Normal case. Its value while halted is don't-care.
- PC arithmetic is unsigned 32-bit. `pc` = 32'hFFFF_FFFC advancing wraps to 0; if that is in range, fetch continues.

## Timing
- Reset (async assert, any time): `pc` = `RESET_PC`, `if_id_pc` = 0, `if_id_instr` = 0, `if_id_valid` = 0, `fetch_count` = 0.
- `halted` after reset is 0 if `RESET_PC` is in range, else 1.
- Reset asserted mid-stall or mid-redirect discards everything; the first edge after deassertion fetches from `RESET_PC`.
- Fetch-to-decode latency: 1 cycle. The instruction at `pc` in cycle N appears on `if_id_*` in cycle N+1.
- Redirect penalty: 1 bubble. With `redirect` in cycle N:
  - cycle N+1: `pc` = target, `if_id_valid` = 0;
  - cycle N+2: target instruction valid in IF/ID.
- Stall and redirect in the same cycle: redirect wins; the flush still occurs.
- `stall` held for K cycles holds IF/ID for K cycles with no duplicate or lost instruction; `fetch_count` advances exactly once per delivered instruction.
- Back-to-back redirects: each one reloads `pc`; `if_id_valid` stays 0 until the first non-redirect, non-stall, in-range cycle.

## Test plan
- **Reset and sequential fetch.** Memory model word i = 32'hA000_0000 + i, `RESET_PC` = 0, no stall or redirect, 8 cycles.
  - Required: `if_id_instr` = A0000000 … A0000006 with `if_id_pc` = 0, 4, …, 24.
  - Then `halted` = 1 at `pc` = 28, `if_id_valid` = 0, `fetch_count` = 7 and holding.
- **Stall.** Assert `stall` for 3 cycles while `pc` = 8.
  - Required: `if_id_instr` holds A0000001 and `pc` holds 8 for 3 cycles.
  - After release, A0000002 is delivered once; `fetch_count` increments by exactly 1 per instruction.
- **Redirect with flush.** Pulse `redirect` with `redirect_pc` = 4 while `pc` = 16.
  - Required: next cycle `pc` = 4, `if_id_valid` = 0; following cycle `if_id_instr` = A0000001, valid = 1.
- **Misaligned target, and redirect + stall together.**
  - Misaligned: `redirect_pc` = 32'h0000_000B → `pc` = 8.
  - Together: `redirect` and `stall` asserted in the same cycle → `pc` takes the target and `if_id_valid` = 0.
- **Recovery from halt.** While halted, `redirect` to 0.
  - Required: `halted` drops next cycle; A0000000 is delivered the cycle after.
- **Async reset mid-run.** Assert `rst_n` low between clock edges at `pc` = 12.
  - Required: immediately `pc` = 0, `if_id_valid` = 0, `fetch_count` = 0.
  - Fetch resumes from 0 after release.
